// File: rtl/keypad_decoder_if.sv
// Scanner-to-decoder link: the one-hot key code in, decoded key state and
// two-digit history out toward the display driver.
interface keypad_decoder_if;
  logic [7:0] key_val;
  logic [3:0] key_hex;
  logic       key_pressed;
  logic       key_pulse;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  modport master (output key_val,
                  input  key_hex, key_pressed, key_pulse, digit_new, digit_old);
  modport slave  (input  key_val,
                  output key_hex, key_pressed, key_pulse, digit_new, digit_old);
endinterface

// File: rtl/keypad_decoder.sv
// Debounces a one-hot row/col keypad code, emits one pulse per accepted press
// and shifts the decoded hex digit into a two-entry history.
module keypad_decoder #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              reset,
  keypad_decoder_if.slave   kif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_e;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] idx4(input logic [3:0] v);
    logic [1:0] i;
    i = 2'd3;
    case (v)
      4'b0001: i = 2'd0;
      4'b0010: i = 2'd1;
      4'b0100: i = 2'd2;
      default: i = 2'd3;
    endcase
    return i;
  endfunction

  function automatic logic [3:0] decode(input logic [7:0] c);
    logic [3:0] h;
    h = 4'h0;
    case ({idx4(c[7:4]), idx4(c[3:0])})
      4'h0: h = 4'h1;  4'h1: h = 4'h2;  4'h2: h = 4'h3;  4'h3: h = 4'hA;
      4'h4: h = 4'h4;  4'h5: h = 4'h5;  4'h6: h = 4'h6;  4'h7: h = 4'hB;
      4'h8: h = 4'h7;  4'h9: h = 4'h8;  4'hA: h = 4'h9;  4'hB: h = 4'hC;
      4'hC: h = 4'hE;  4'hD: h = 4'h0;  4'hE: h = 4'hF;  4'hF: h = 4'hD;
      default: h = 4'h0;
    endcase
    return h;
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_hex_q, key_hex_d;
  logic          key_pressed_q, key_pressed_d;
  logic          key_pulse_q, key_pulse_d;
  logic [3:0]    digit_new_q, digit_new_d;
  logic [3:0]    digit_old_q, digit_old_d;

  logic valid, match;
  assign valid = onehot4(kif.key_val[7:4]) && onehot4(kif.key_val[3:0]);
  assign match = (kif.key_val == cand_q);

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    key_hex_d     = key_hex_q;
    key_pressed_d = key_pressed_q;
    key_pulse_d   = 1'b0;
    digit_new_d   = digit_new_q;
    digit_old_d   = digit_old_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          cand_d  = kif.key_val;
          cnt_d   = ONE;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (match) begin
          if (cnt_q == LAST) begin
            state_d       = HELD;
            cnt_d         = '0;
            key_hex_d     = decode(cand_q);
            digit_old_d   = digit_new_q;
            digit_new_d   = decode(cand_q);
            key_pressed_d = 1'b1;
            key_pulse_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (valid) begin
          cand_d = kif.key_val;
          cnt_d  = ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (!match) begin
          cnt_d   = ONE;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // a returning key is a glitch, not a new press
        if (match) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d       = IDLE;
          cnt_d         = '0;
          key_pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      key_hex_q     <= '0;
      key_pressed_q <= 1'b0;
      key_pulse_q   <= 1'b0;
      digit_new_q   <= '0;
      digit_old_q   <= '0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      key_hex_q     <= key_hex_d;
      key_pressed_q <= key_pressed_d;
      key_pulse_q   <= key_pulse_d;
      digit_new_q   <= digit_new_d;
      digit_old_q   <= digit_old_d;
    end
  end

  assign kif.key_hex     = key_hex_q;
  assign kif.key_pressed = key_pressed_q;
  assign kif.key_pulse   = key_pulse_q;
  assign kif.digit_new   = digit_new_q;
  assign kif.digit_old   = digit_old_q;
endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder (DEBOUNCE_CYCLES=4): expected pulses are
// queued when a press is driven and matched as the DUT strobes key_pulse.
module tb_keypad_decoder;
  localparam int D = 4;

  typedef struct {
    int         at;
    logic [3:0] hex;
    logic [3:0] dnew;
    logic [3:0] dold;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  exp_t sb[$];
  logic [3:0] m_new = 4'h0;
  logic [3:0] m_old = 4'h0;

  keypad_decoder_if kif();
  keypad_decoder #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .reset(reset), .kif(kif));

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // called at posedge+1; `lat` edges later the pulse is expected
  task automatic push(input int lat, input logic [3:0] hex);
    exp_t e;
    e.at = edge_n + lat; e.hex = hex; e.dnew = hex; e.dold = m_new;
    sb.push_back(e);
    m_old = m_new;
    m_new = hex;
  endtask

  task automatic step(input logic [7:0] v, input int n);
    kif.key_val = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hex"}, 32'(kif.key_hex), 32'h0);
    chk({tag, "_pressed"}, 32'(kif.key_pressed), 32'h0);
    chk({tag, "_pulse"}, 32'(kif.key_pulse), 32'h0);
    chk({tag, "_new"}, 32'(kif.digit_new), 32'h0);
    chk({tag, "_old"}, 32'(kif.digit_old), 32'h0);
  endtask

  task automatic press_release(input logic [7:0] v, input logic [3:0] hex);
    push(D, hex);
    step(v, 6);
    step(8'h00, 8);
  endtask

  always @(negedge clk) begin
    if (!reset && kif.key_pulse) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_edge", 32'(edge_n), 32'(e.at));
        chk("pulse_hex", 32'(kif.key_hex), 32'(e.hex));
        chk("pulse_new", 32'(kif.digit_new), 32'(e.dnew));
        chk("pulse_old", 32'(kif.digit_old), 32'(e.dold));
        chk("pulse_pressed", 32'(kif.key_pressed), 32'h1);
      end
    end
  end

  initial begin
    kif.key_val = 8'h00;
    #1 chk_zero("rst_async");
    @(posedge clk); #1;
    chk_zero("rst_held");
    reset = 1'b0;
    @(posedge clk); #1;

    // clean press, exact release latency
    push(D, 4'h1);
    step(8'b0001_0001, 10);
    chk("clean_pressed", 32'(kif.key_pressed), 32'h1);
    step(8'h00, 3);
    chk("clean_rel_early", 32'(kif.key_pressed), 32'h1);
    step(8'h00, 1);
    chk("clean_rel", 32'(kif.key_pressed), 32'h0);
    chk("clean_hex_hold", 32'(kif.key_hex), 32'h1);
    step(8'h00, 6);

    // bounce: two samples, a gap, then stable
    step(8'b0010_0100, 2);
    step(8'h00, 1);
    push(D, 4'h6);
    step(8'b0010_0100, 6);
    step(8'h00, 8);

    // digit shift and row-3 decodes
    press_release(8'b0100_0010, 4'h8);
    press_release(8'b1000_0010, 4'h0);
    chk("shift_new", 32'(kif.digit_new), 32'h0);
    chk("shift_old", 32'(kif.digit_old), 32'h8);
    press_release(8'b1000_0001, 4'hE);
    press_release(8'b1000_1000, 4'hD);

    // invalid multi-hot code never debounces
    step(8'b0011_0001, 10);
    chk("invalid_pressed", 32'(kif.key_pressed), 32'h0);
    step(8'h00, 2);

    // rollover: second key only counts after the first is released
    push(D, 4'h1);
    step(8'b0001_0001, 6);
    push(2 * D, 4'h2);
    step(8'b0001_0010, 3);
    chk("roll_still_held", 32'(kif.key_pressed), 32'h1);
    step(8'b0001_0010, 1);
    chk("roll_released", 32'(kif.key_pressed), 32'h0);
    step(8'b0001_0010, 8);
    chk("roll_hex", 32'(kif.key_hex), 32'h2);
    step(8'h00, 8);

    // release glitch shorter than the debounce window
    push(D, 4'h3);
    step(8'b0001_0100, 6);
    step(8'h00, 2);
    step(8'b0001_0100, 6);
    chk("glitch_pressed", 32'(kif.key_pressed), 32'h1);
    step(8'h00, 8);

    // async reset mid-debounce, between edges
    step(8'b0001_1000, 2);
    #2 reset = 1'b1;
    #1 chk_zero("rst_debounce");
    reset = 1'b0;
    m_new = 4'h0; m_old = 4'h0;
    @(posedge clk); #1;
    step(8'h00, 2);

    // async reset mid-held
    push(D, 4'h2);
    step(8'b0001_0010, 6);
    #2 reset = 1'b1;
    #1 chk_zero("rst_held_state");
    reset = 1'b0;
    m_new = 4'h0; m_old = 4'h0;
    @(posedge clk); #1;
    step(8'h00, 2);

    push(D, 4'h7);
    step(8'b0100_0001, 6);
    chk("post_rst_pressed", 32'(kif.key_pressed), 32'h1);
    chk("post_rst_old", 32'(kif.digit_old), 32'h0);
    step(8'h00, 10);

    chk("pending_pulses", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
